// File: rtl/rtc_pkg.sv
// Shared encodings, field ranges and the month-length helper for the
// settable real-time calendar.
package rtc_pkg;

    localparam logic [2:0] FLD_YEAR   = 3'd0;
    localparam logic [2:0] FLD_MONTH  = 3'd1;
    localparam logic [2:0] FLD_DAY    = 3'd2;
    localparam logic [2:0] FLD_HOUR   = 3'd3;
    localparam logic [2:0] FLD_MINUTE = 3'd4;
    localparam logic [2:0] FLD_SECOND = 3'd5;

    localparam logic [7:0] YEAR_MIN   = 8'd0;
    localparam logic [7:0] YEAR_MAX   = 8'd99;
    localparam logic [7:0] MONTH_MIN  = 8'd1;
    localparam logic [7:0] MONTH_MAX  = 8'd12;
    localparam logic [7:0] DAY_MIN    = 8'd1;
    localparam logic [7:0] HOUR_MIN   = 8'd0;
    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MIN = 8'd0;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } cal_t;

    // Years are 2000..2099, so divisible-by-4 is the full leap rule.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
            8'd2:                    days_in_month = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 days_in_month = 8'd31;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-switch debouncer: the accepted level flips only after the raw input
// has disagreed with it for DEBOUNCE_CYC consecutive cycles.
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= raw;
                rise  <= raw;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_calendar_set.sv
// Date/time counter with 1 Hz prescaler, leap-aware calendar and a
// switch-driven set mode (field select, inc/dec, blink flag).
module rtc_calendar_set
    import rtc_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BLINK_CYC    = 12500000,
    parameter int RESET_YEAR   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic [7:0] year,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       set_mode,
    output logic [2:0] set_field,
    output logic       blink,
    output logic       tick_1hz
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam cal_t RESET_CAL = '{8'(RESET_YEAR), MONTH_MIN, DAY_MIN,
                                   HOUR_MIN, MINSEC_MIN, MINSEC_MIN};

    logic [3:0]    rise;
    logic [3:0]    level;
    logic [3:0]    press;
    logic [0:0]    state;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    field;
    logic          blink_q;
    logic          tick_q;
    cal_t          cal;
    cal_t          cal_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_db
        sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    // A rise is only acted on while its accepted level is still high.
    assign press = rise & level;

    function automatic logic [7:0] step(input logic [7:0] v,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi,
                                        input logic       up);
        if (up) step = (v >= hi) ? lo : v + 8'd1;
        else    step = (v <= lo) ? hi : v - 8'd1;
    endfunction

    function automatic cal_t advance(input cal_t c);
        cal_t r;
        r = c;
        if (c.second != MINSEC_MAX) begin
            r.second = c.second + 8'd1;
        end else begin
            r.second = MINSEC_MIN;
            if (c.minute != MINSEC_MAX) begin
                r.minute = c.minute + 8'd1;
            end else begin
                r.minute = MINSEC_MIN;
                if (c.hour != HOUR_MAX) begin
                    r.hour = c.hour + 8'd1;
                end else begin
                    r.hour = HOUR_MIN;
                    if (c.day < days_in_month(c.month, c.year)) begin
                        r.day = c.day + 8'd1;
                    end else begin
                        r.day = DAY_MIN;
                        if (c.month != MONTH_MAX) begin
                            r.month = c.month + 8'd1;
                        end else begin
                            r.month = MONTH_MIN;
                            r.year  = (c.year >= YEAR_MAX) ? YEAR_MIN : c.year + 8'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Edits never carry; the day clamp keeps the date legal after a
    // month or year change.
    function automatic cal_t edit(input cal_t c, input logic [2:0] f, input logic up);
        cal_t       r;
        logic [7:0] dim;
        r = c;
        case (f)
            FLD_YEAR:   r.year   = step(c.year, YEAR_MIN, YEAR_MAX, up);
            FLD_MONTH:  r.month  = step(c.month, MONTH_MIN, MONTH_MAX, up);
            FLD_DAY:    r.day    = step(c.day, DAY_MIN, days_in_month(c.month, c.year), up);
            FLD_HOUR:   r.hour   = step(c.hour, HOUR_MIN, HOUR_MAX, up);
            FLD_MINUTE: r.minute = step(c.minute, MINSEC_MIN, MINSEC_MAX, up);
            FLD_SECOND: r.second = step(c.second, MINSEC_MIN, MINSEC_MAX, up);
            default:    r = c;
        endcase
        dim = days_in_month(r.month, r.year);
        if (r.day > dim) r.day = dim;
        return r;
    endfunction

    always_comb begin
        presc_nxt = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        cal_nxt   = cal;
        if (state == ST_RUN) begin
            if (tick_q) cal_nxt = advance(cal);
        end else if (press[2] ^ press[3]) begin
            cal_nxt = edit(cal, field, press[2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            presc     <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            tick_q    <= 1'b0;
            field     <= FLD_YEAR;
            cal       <= RESET_CAL;
        end else if (press[0]) begin
            // Mode toggle wins over any simultaneous edit or tick.
            state     <= (state == ST_RUN) ? ST_SET : ST_RUN;
            presc     <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            tick_q    <= 1'b0;
            field     <= FLD_YEAR;
        end else if (state == ST_RUN) begin
            presc  <= presc_nxt;
            tick_q <= (presc_nxt == PRESC_LAST);
            cal    <= cal_nxt;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            if (press[1]) field <= (field == FLD_SECOND) ? FLD_YEAR : field + 3'd1;
            cal <= cal_nxt;
        end
    end

    assign year      = cal.year;
    assign month     = cal.month;
    assign day       = cal.day;
    assign hour      = cal.hour;
    assign minute    = cal.minute;
    assign second    = cal.second;
    assign set_mode  = (state == ST_SET);
    assign set_field = field;
    assign blink     = blink_q;
    assign tick_1hz  = tick_q;

endmodule

// File: tb/tb_rtc_calendar_set.sv
// Directed bench for rtc_calendar_set: rollover, leap years, set-mode edits,
// day clamp, debounce and reset during set mode.
`timescale 1ns/1ps
module tb_rtc_calendar_set;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int BLINK  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic [7:0] year, month, day, hour, minute, second;
    logic       set_mode;
    logic [2:0] set_field;
    logic       blink;
    logic       tick_1hz;

    int total = 0;
    int bad   = 0;
    int cur_fld = 0;

    always #5 clk = ~clk;

    rtc_calendar_set #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .BLINK_CYC(BLINK), .RESET_YEAR(0)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in),
        .year(year), .month(month), .day(day),
        .hour(hour), .minute(minute), .second(second),
        .set_mode(set_mode), .set_field(set_field),
        .blink(blink), .tick_1hz(tick_1hz)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int i);
        sw_in[i] = 1'b1;
        cyc(DEB + 1);
        sw_in[i] = 1'b0;
        cyc(DEB + 1);
    endtask

    function automatic logic [7:0] fval(input int f);
        case (f)
            0:       return year;
            1:       return month;
            2:       return day;
            3:       return hour;
            4:       return minute;
            default: return second;
        endcase
    endfunction

    task automatic goto_field(input int f);
        while (cur_fld != f) begin
            press(1);
            cur_fld = (cur_fld + 1) % 6;
        end
    endtask

    task automatic set_val(input int f, input logic [7:0] tgt);
        int n;
        n = 0;
        goto_field(f);
        while (fval(f) !== tgt && n < 120) begin
            if (tgt < fval(f)) press(3);
            else               press(2);
            n++;
        end
        total++;
        if (fval(f) !== tgt) begin
            bad++;
            $display("FAIL set_val field %0d: got %0d want %0d", f, fval(f), tgt);
        end
    endtask

    task automatic set_all(input logic [7:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        set_val(0, y);
        set_val(1, mo);
        set_val(2, d);
        set_val(3, h);
        set_val(4, mi);
        set_val(5, s);
    endtask

    task automatic enter_set(input string name);
        press(0);
        cur_fld = 0;
        total++;
        if (set_mode !== 1'b1 || set_field !== 3'd0 || tick_1hz !== 1'b0) begin
            bad++;
            $display("FAIL %s enter: set_mode=%b field=%0d tick=%b want 1 0 0",
                     name, set_mode, set_field, tick_1hz);
        end
    endtask

    task automatic exit_and_tick(input string name, input logic [47:0] exp);
        int k, ticks, first;
        sw_in[0] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (set_mode !== 1'b0 && k < 20);
        cur_fld = 0;
        total++;
        if (set_mode !== 1'b0 || set_field !== 3'd0 || blink !== 1'b0) begin
            bad++;
            $display("FAIL %s exit: set_mode=%b field=%0d blink=%b want 0 0 0",
                     name, set_mode, set_field, blink);
        end
        ticks = 0;
        first = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == DEB + 1) sw_in[0] = 1'b0;
            if (tick_1hz === 1'b1) begin
                ticks++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (ticks != 1 || first != CLK_HZ - 1) begin
            bad++;
            $display("FAIL %s tick: count=%0d first=%0d want 1 at %0d",
                     name, ticks, first, CLK_HZ - 1);
        end
        total++;
        if ({year, month, day, hour, minute, second} !== exp) begin
            bad++;
            $display("FAIL %s time: got %0d-%0d-%0d %0d:%0d:%0d want %0d-%0d-%0d %0d:%0d:%0d",
                     name, year, month, day, hour, minute, second,
                     exp[47:40], exp[39:32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sw_in = 4'b0;
        cyc(3);
        rst = 1'b0;
        total++;
        if ({year, month, day, hour, minute, second} !== {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset time: got %0d-%0d-%0d %0d:%0d:%0d want 0-1-1 0:0:0",
                     year, month, day, hour, minute, second);
        end
        total++;
        if (set_mode !== 1'b0 || set_field !== 3'd0 || blink !== 1'b0 || tick_1hz !== 1'b0) begin
            bad++;
            $display("FAIL reset ctrl: set_mode=%b field=%0d blink=%b tick=%b want 0 0 0 0",
                     set_mode, set_field, blink, tick_1hz);
        end
    endtask

    task automatic test_rollover();
        enter_set("rollover");
        set_all(8'd23, 8'd12, 8'd31, 8'd23, 8'd59, 8'd59);
        exit_and_tick("rollover", {8'd24, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0});
    endtask

    task automatic test_leap();
        enter_set("leap24");
        set_all(8'd24, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59);
        exit_and_tick("leap24", {8'd24, 8'd2, 8'd29, 8'd0, 8'd0, 8'd0});
        enter_set("nonleap23");
        set_all(8'd23, 8'd2, 8'd28, 8'd23, 8'd59, 8'd59);
        exit_and_tick("nonleap23", {8'd23, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0});
    endtask

    task automatic test_edit();
        int toggles, ticks;
        logic prev;
        enter_set("edit");
        set_all(8'd23, 8'd1, 8'd31, 8'd10, 8'd59, 8'd30);
        goto_field(0);
        total++;
        if (set_field !== 3'd0) begin
            bad++;
            $display("FAIL edit next_wrap: field=%0d want 0", set_field);
        end
        goto_field(4);
        total++;
        if (set_field !== 3'd4) begin
            bad++;
            $display("FAIL edit goto4: field=%0d want 4", set_field);
        end
        press(2);
        total++;
        if ({hour, minute} !== {8'd10, 8'd0}) begin
            bad++;
            $display("FAIL edit inc_wrap: hour=%0d minute=%0d want 10 0", hour, minute);
        end
        press(3);
        total++;
        if ({hour, minute} !== {8'd10, 8'd59}) begin
            bad++;
            $display("FAIL edit dec_wrap: hour=%0d minute=%0d want 10 59", hour, minute);
        end
        toggles = 0;
        ticks   = 0;
        prev    = blink;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (blink !== prev) toggles++;
            if (tick_1hz !== 1'b0) ticks++;
            prev = blink;
        end
        total++;
        if (toggles != 3 || ticks != 0) begin
            bad++;
            $display("FAIL edit blink: toggles=%0d ticks=%0d want 3 0", toggles, ticks);
        end
    endtask

    task automatic test_clamp();
        set_all(8'd23, 8'd3, 8'd31, 8'd0, 8'd0, 8'd0);
        goto_field(1);
        press(2);
        total++;
        if ({month, day} !== {8'd4, 8'd30}) begin
            bad++;
            $display("FAIL clamp apr: month=%0d day=%0d want 4 30", month, day);
        end
        set_all(8'd23, 8'd1, 8'd31, 8'd0, 8'd0, 8'd0);
        goto_field(1);
        press(2);
        total++;
        if ({month, day} !== {8'd2, 8'd28}) begin
            bad++;
            $display("FAIL clamp feb: month=%0d day=%0d want 2 28", month, day);
        end
    endtask

    task automatic test_debounce();
        goto_field(4);
        sw_in[2] = 1'b1;
        cyc(DEB - 1);
        sw_in[2] = 1'b0;
        cyc(DEB + 2);
        total++;
        if (minute !== 8'd0) begin
            bad++;
            $display("FAIL debounce glitch: minute=%0d want 0", minute);
        end
        press(2);
        total++;
        if (minute !== 8'd1) begin
            bad++;
            $display("FAIL debounce stable: minute=%0d want 1", minute);
        end
        sw_in[3:2] = 2'b11;
        cyc(DEB + 1);
        sw_in[3:2] = 2'b00;
        cyc(DEB + 1);
        total++;
        if (minute !== 8'd1) begin
            bad++;
            $display("FAIL debounce inc_dec: minute=%0d want 1", minute);
        end
    endtask

    task automatic test_reset_mid_set();
        goto_field(2);
        total++;
        if (set_field !== 3'd2 || set_mode !== 1'b1) begin
            bad++;
            $display("FAIL midset pre: field=%0d set_mode=%b want 2 1", set_field, set_mode);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_fld = 0;
        total++;
        if ({year, month, day, hour, minute, second} !== {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL midset time: got %0d-%0d-%0d %0d:%0d:%0d want 0-1-1 0:0:0",
                     year, month, day, hour, minute, second);
        end
        total++;
        if (set_mode !== 1'b0 || blink !== 1'b0 || set_field !== 3'd0 || tick_1hz !== 1'b0) begin
            bad++;
            $display("FAIL midset ctrl: set_mode=%b blink=%b field=%0d tick=%b want 0 0 0 0",
                     set_mode, blink, set_field, tick_1hz);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rollover();
        test_leap();
        test_edit();
        test_clamp();
        test_debounce();
        test_reset_mid_set();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
